mux_wh_arbiter: RTL
===================

Name: mux_wh_arbiter

Overview:
- Wormhole packet arbiter that drives the one-hot `sel` of the 2:1 router output mux, sharing output port 0 between input ports 0 and 1.
- Locks the output to one input from head flit to tail flit.
- Uses round-robin priority between packets and applies downstream backpressure.
- Releases a stalled packet lock after a programmable idle timeout.

Parameters:
- SELW, 5, width of mux `sel` bus; one-hot, only bits [1:0] used, upper bits always 0.
- TYPEW, 2, width of flit-type field extracted from the top of each idata.
- CNTW, 8, width of accepted-flit counter of the current packet.
- TIMEOUT, 16, idle cycles tolerated while locked before forced release; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- ivalid_0  in  1  input 0 flit valid.
- itype_0  in  TYPEW  input 0 flit type (top bits of idata_0).
- ivalid_1  in  1  input 1 flit valid.
- itype_1  in  TYPEW  input 1 flit type.
- ordy  in  1  downstream accepts a flit this cycle.
- sel  out  SELW  one-hot mux select: 2'b01 selects port 0, 2'b10 selects port 1, all-zero when idle; registered.
- ogrant_0  out  1  input 0 flit consumed this cycle; combinational.
- ogrant_1  out  1  input 1 flit consumed this cycle; combinational.
- obusy  out  1  arbiter locked to a packet.
- oflit_cnt  out  CNTW  flits accepted in the current packet; saturating.
- otimeout  out  1  one-cycle pulse on forced release.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; clock port is `clk`, reset port is `rst`.
- Reset values: state IDLE, sel=0, prio=0 (port 0 preferred), idle counter 0, oflit_cnt=0, otimeout=0, obusy=0, ogrant_*=0.
- Reset asserted mid-packet aborts the lock immediately on the next edge; no tail is required.
- States: IDLE, LOCK0, LOCK1.
- IDLE:
  - A request is ivalid_x=1 with itype_x==TYPE_HEAD.
  - One request: go to LOCKx.
  - Two requests: choose the port equal to prio.
  - Non-head flits are ignored; no grant is issued in IDLE.
- Entering LOCKx:
  - sel becomes one-hot(x) on the same edge that enters LOCKx.
  - obusy=1 and oflit_cnt=0 on entry.
  - Grant latency is one cycle: head seen in cycle N, sel and grant valid from cycle N+1. The source holds the head until granted.
- LOCKx, per cycle:
  - ogrant_x = ivalid_x & ordy.
  - The other port's grant is 0.
- Each granted flit:
  - oflit_cnt increments and saturates at 2^CNTW-1.
  - The idle counter clears.
- Granted flit with itype_x==TYPE_TAIL: next state IDLE, sel=0, prio = other port, oflit_cnt holds its final value until the next lock.
- A new head in the cycle after release is arbitrated normally. There is no back-to-back bypass, so there is one dead cycle between packets.
- Timeout:
  - In LOCKx, the idle counter increments while ivalid_x=0. Cycles with ivalid_x=1 and ordy=0 do not count (backpressure is not idle).
  - If TIMEOUT>0 and the counter reaches TIMEOUT, the next state is IDLE with sel=0, prio = other port, and otimeout pulses for 1 cycle.
- Head flits arriving on the locked port mid-packet are treated as data. They are granted and do not restart the packet.
- A tail with ordy=0 is not consumed; the lock is held until the tail is granted.
- Flit type encoding (package): TYPE_NONE=2'b00, TYPE_HEAD=2'b01, TYPE_DATA=2'b10, TYPE_TAIL=2'b11.

Decomposition:
- Shared package / `define file: TYPE_* encodings, TYPEW, SELW, state encodings, sel one-hot constants SEL_P0/SEL_P1/SEL_NONE.
- One sub-module: `rr_pick2`, a combinational 2-requester priority picker with inputs req[1:0] and prio, output grant index. It is reused by wider arbiters later.
- Timeout/idle counter and FSM live in the top.

Test Plan:
- Reset, then head on port 1 only at cycle 3 -> sel=2'b10 at cycle 4, ogrant_1=1 with ordy=1; 20 data flits + tail granted; sel=0 the cycle after the tail; oflit_cnt=22.
- Simultaneous heads on ports 0 and 1 after reset -> port 0 wins (prio=0). After port 0's tail, port 1 locks with 1 dead cycle between. The next simultaneous heads go to port 0 again.
- ordy low for 5 cycles mid-packet with ivalid held -> no grants, no timeout, sel stable; the packet completes after ordy returns; oflit_cnt counts only granted flits.
- Port 0 locked, source drops ivalid for 16 cycles (TIMEOUT=16) -> otimeout pulses once at the 16th idle cycle, sel=0 next cycle, prio=1; a waiting port 1 head is granted afterwards.
- rst pulsed while LOCK1 mid-packet -> next cycle sel=0, obusy=0, oflit_cnt=0, prio=0; port 1 data flits without a head receive no grant.
- Port 0 sends a 1-flit packet (head, then tail) while port 1 streams non-head DATA flits in IDLE -> only port 0 is granted; port 1 is never selected.

Source files
------------

// File: rtl/mux_wh_arbiter_pkg.sv
// Shared definitions for the wormhole output-port arbiter.
//   - Flit type encodings carried in the top TYPEW bits of each idata word.
//   - Arbiter FSM state encoding.
//   - One-hot select constants for the 2:1 router output mux.
package mux_wh_arbiter_pkg;

    localparam int TYPEW = 2;
    localparam int SELW  = 5;

    localparam logic [TYPEW-1:0] TYPE_NONE = 2'b00;
    localparam logic [TYPEW-1:0] TYPE_HEAD = 2'b01;
    localparam logic [TYPEW-1:0] TYPE_DATA = 2'b10;
    localparam logic [TYPEW-1:0] TYPE_TAIL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    localparam logic [SELW-1:0] SEL_NONE = 5'b00000;
    localparam logic [SELW-1:0] SEL_P0   = 5'b00001;
    localparam logic [SELW-1:0] SEL_P1   = 5'b00010;

    // Mux select pattern for a given input port index.
    function automatic logic [SELW-1:0] sel_onehot(input logic port);
        return port ? SEL_P1 : SEL_P0;
    endfunction

endpackage

// File: rtl/mux_wh_arbiter_rr_pick2.sv
// rr_pick2: combinational two-requester priority picker.
//   req[1:0] : request per requester
//   prio     : requester index that wins when both request
//   gnt_idx  : index of the chosen requester (only meaningful when |req)
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       gnt_idx
);

    always_comb begin
        gnt_idx = 1'b0;
        if (req == 2'b11) begin
            gnt_idx = prio;
        end else begin
            // Single requester (or none): pick whichever is asking.
            gnt_idx = req[1];
        end
    end

endmodule

// File: rtl/mux_wh_arbiter.sv
// mux_wh_arbiter: wormhole packet arbiter sharing output port 0 between
// input ports 0 and 1. A head flit locks the output to its port until the
// tail is consumed; ties between heads go round-robin; a lock whose source
// stops sending is dropped after TIMEOUT idle cycles.
//   clk, rst            : clock, synchronous active-high reset
//   ivalid_x, itype_x   : per-input flit valid and flit type
//   ordy                : downstream accepts a flit this cycle
//   sel                 : registered one-hot mux select (0 when idle)
//   ogrant_x            : combinational flit-consumed strobe per input
//   obusy               : locked to a packet
//   oflit_cnt           : saturating count of flits accepted in this packet
//   otimeout            : one-cycle pulse in the cycle a lock is forced off
module mux_wh_arbiter #(
    parameter int SELW    = 5,
    parameter int TYPEW   = 2,
    parameter int CNTW    = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ivalid_0,
    input  logic [TYPEW-1:0] itype_0,
    input  logic             ivalid_1,
    input  logic [TYPEW-1:0] itype_1,
    input  logic             ordy,
    output logic [SELW-1:0]  sel,
    output logic             ogrant_0,
    output logic             ogrant_1,
    output logic             obusy,
    output logic [CNTW-1:0]  oflit_cnt,
    output logic             otimeout
);

    import mux_wh_arbiter_pkg::*;

    localparam int                IDLEW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDLEW-1:0]  IDLE_LAST = IDLEW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNTW-1:0]   CNT_MAX   = '1;
    localparam logic              TO_ENABLE = (TIMEOUT > 0);

    state_t           state_reg, state_next;
    logic [SELW-1:0]  sel_reg, sel_next;
    logic             prio_reg, prio_next;
    logic [IDLEW-1:0] idle_cnt_reg, idle_cnt_next;
    logic [CNTW-1:0]  flit_cnt_reg, flit_cnt_next;

    logic [1:0]       port_valid;
    logic [TYPEW-1:0] port_type [2];
    logic [1:0]       head_req;
    logic [1:0]       port_grant;
    logic             pick_idx;

    logic             locked;
    logic             lock_port;
    logic             lock_valid;
    logic             lock_tail;
    logic             grant;
    logic             timeout_hit;

    assign port_valid   = {ivalid_1, ivalid_0};
    assign port_type[0] = itype_0;
    assign port_type[1] = itype_1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign head_req[gi]   = port_valid[gi] & (port_type[gi] == TYPE_HEAD);
        assign port_grant[gi] = grant & (lock_port == gi[0]);
    end

    rr_pick2 u_pick (
        .req     (head_req),
        .prio    (prio_reg),
        .gnt_idx (pick_idx)
    );

    always_comb begin
        locked     = (state_reg != IDLE);
        lock_port  = (state_reg == LOCK1);
        lock_valid = port_valid[lock_port];
        lock_tail  = (port_type[lock_port] == TYPE_TAIL);
        // Grants are suppressed during reset so nothing is consumed by a
        // lock that is being torn down on this edge.
        grant      = locked & lock_valid & ordy & ~rst;
        // Only a truly empty source counts as idle; backpressure never does.
        timeout_hit = TO_ENABLE & locked & ~lock_valid & ~rst &
                      (idle_cnt_reg == IDLE_LAST);
    end

    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        prio_next     = prio_reg;
        idle_cnt_next = idle_cnt_reg;
        flit_cnt_next = flit_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (|head_req) begin
                    state_next    = pick_idx ? LOCK1 : LOCK0;
                    sel_next      = SELW'(sel_onehot(pick_idx));
                    idle_cnt_next = '0;
                    flit_cnt_next = '0;
                end
            end
            LOCK0, LOCK1: begin
                if (grant) begin
                    idle_cnt_next = '0;
                    if (flit_cnt_reg != CNT_MAX) begin
                        flit_cnt_next = flit_cnt_reg + 1'b1;
                    end
                    if (lock_tail) begin
                        state_next = IDLE;
                        sel_next   = SELW'(SEL_NONE);
                        prio_next  = ~lock_port;
                    end
                end else if (!lock_valid) begin
                    if (timeout_hit) begin
                        state_next    = IDLE;
                        sel_next      = SELW'(SEL_NONE);
                        prio_next     = ~lock_port;
                        idle_cnt_next = '0;
                    end else if (TO_ENABLE) begin
                        idle_cnt_next = idle_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                sel_next   = SELW'(SEL_NONE);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            sel_reg      <= '0;
            prio_reg     <= 1'b0;
            idle_cnt_reg <= '0;
            flit_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            prio_reg     <= prio_next;
            idle_cnt_reg <= idle_cnt_next;
            flit_cnt_reg <= flit_cnt_next;
        end
    end

    assign sel       = sel_reg;
    assign ogrant_0  = port_grant[0];
    assign ogrant_1  = port_grant[1];
    assign obusy     = locked;
    assign oflit_cnt = flit_cnt_reg;
    assign otimeout  = timeout_hit;

endmodule
